// File: rtl/exp_key_recover.sv
// Key recovery engine: key = base^log_key, saturating at 2^W-1.
// Square-and-multiply, one exponent bit per clock, LSB first.
module exp_key_recover #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] base,
  input  logic [W-1:0] log_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] key,
  output logic         overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [W-1:0] acc, acc_n;
  logic [W-1:0] b, b_n;
  logic [W-1:0] e, e_n;
  logic [W-1:0] key_n;
  logic         acc_sat, acc_sat_n;
  logic         b_sat, b_sat_n;
  logic         ov_n;

  logic [2*W-1:0] pa, pb;
  logic [W-1:0]   acc_m, b_m;
  logic           acc_hi, b_hi;
  logic           acc_sat_m, b_sat_m;

  assign pa = {{W{1'b0}}, acc} * {{W{1'b0}}, b};
  assign pb = {{W{1'b0}}, b} * {{W{1'b0}}, b};

  assign acc_hi = |pa[2*W-1:W];
  assign b_hi   = |pb[2*W-1:W];
  assign acc_m  = acc_hi ? {W{1'b1}} : pa[W-1:0];
  assign b_m    = b_hi ? {W{1'b1}} : pb[W-1:0];

  // A saturated factor only taints a nonzero partner; x*0 stays exact.
  assign acc_sat_m = acc_sat | (b_sat & (|acc)) | acc_hi;
  assign b_sat_m   = b_sat | (b_sat & (|b)) | b_hi;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    acc_sat_n = acc_sat;
    b_n       = b;
    b_sat_n   = b_sat;
    e_n       = e;
    key_n     = key;
    ov_n      = overflow;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          acc_n     = {{(W-1){1'b0}}, 1'b1};
          acc_sat_n = 1'b0;
          b_n       = base;
          b_sat_n   = 1'b0;
          e_n       = log_key;
          state_n   = RUN;
        end
      end
      RUN: begin
        if (e[0]) begin
          acc_n     = acc_m;
          acc_sat_n = acc_sat_m;
        end
        b_n     = b_m;
        b_sat_n = b_sat_m;
        e_n     = e >> 1;
        if (e[W-1:1] == '0) begin
          key_n   = acc_sat_n ? {W{1'b1}} : acc_n;
          ov_n    = acc_sat_n;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      acc_sat  <= 1'b0;
      b        <= '0;
      b_sat    <= 1'b0;
      e        <= '0;
      key      <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      acc_sat  <= acc_sat_n;
      b        <= b_n;
      b_sat    <= b_sat_n;
      e        <= e_n;
      key      <= key_n;
      overflow <= ov_n;
    end
  end

endmodule

// File: tb/tb_exp_key_recover.sv
// Bench for exp_key_recover: directed cases, reset abort,
// randomized ops with stalls against a saturating power model.
module tb_exp_key_recover;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] base;
  logic [31:0] log_key;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] key;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exp_key_recover #(.W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .base     (base),
    .log_key  (log_key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .key      (key),
    .overflow (overflow)
  );

  // True power by repeated multiplication, stopping once it exceeds 32 bits.
  function automatic void model(input logic [31:0] bs, input logic [31:0] ex,
                                output logic [31:0] k, output bit ov);
    longint unsigned r;
    r  = 1;
    ov = 0;
    if (ex == 0) r = 1;
    else if (bs == 0) r = 0;
    else if (bs == 1) r = 1;
    else begin
      for (longint unsigned i = 0; i < ex; i++) begin
        r = r * bs;
        if (r > 64'h0000_0000_FFFF_FFFF) begin
          ov = 1;
          break;
        end
      end
    end
    k = ov ? 32'hFFFF_FFFF : r[31:0];
  endfunction

  function automatic int nbits(input logic [31:0] x);
    int n;
    n = 0;
    while (x != 0) begin
      n++;
      x = x >> 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation; stall = cycles to hold out_ready low in DONE.
  task automatic run_op(input logic [31:0] bs, input logic [31:0] ex,
                        input int stall, input bit noisy);
    logic [31:0] ek;
    bit          eov;
    int          n, lat;
    logic [31:0] k0;
    model(bs, ex, ek, eov);
    n = nbits(ex);
    in_valid = 1'b1;
    base     = bs;
    log_key  = ex;
    chk("in_ready_idle", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    if (noisy) begin
      base     = $urandom;
      log_key  = $urandom;
      in_valid = 1'($urandom_range(0, 1));
    end
    lat = 0;
    do begin
      out_ready = (noisy && lat + 1 < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      lat++;
      if (in_ready && out_valid) chk("ready_valid_excl", 1'b1, 1'b0);
    end while (!out_valid && lat < 64);
    out_ready = 1'b0;
    chk("latency", 64'(lat), 64'(n));
    chk("key", key, ek);
    chk("overflow", overflow, eov);
    chk("in_ready_busy", in_ready, 1'b0);
    k0 = key;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (key !== k0 || !out_valid) chk("hold_stable", {key, 31'b0, out_valid}, {k0, 32'b1});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drop_valid", out_valid, 1'b0);
    chk("back_idle", in_ready, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    base      = '0;
    log_key   = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_key", key, 32'h0);
    chk("rst_overflow", overflow, 1'b0);

    run_op(32'd3, 32'd5, 4, 0);
    chk("k243", key, 32'd243);
    run_op(32'd2, 32'd31, 0, 0);
    chk("k2p31", key, 32'h8000_0000);
    run_op(32'd2, 32'd32, 0, 0);
    chk("ov2p32", overflow, 1'b1);
    run_op(32'd7, 32'd0, 0, 0);
    run_op(32'd0, 32'd0, 0, 0);
    chk("k0p0", key, 32'd1);
    run_op(32'd0, 32'd9, 0, 0);
    chk("k0p9", key, 32'd0);
    run_op(32'h0001_0000, 32'd2, 0, 0);
    chk("k64k_sq", key, 32'hFFFF_FFFF);
    run_op(32'h0000_FFFF, 32'd2, 0, 0);
    chk("kffff_sq", key, 32'hFFFE_0001);
    run_op(32'd1, 32'hFFFF_FFFF, 0, 0);

    // Reset mid-RUN aborts the operation.
    in_valid = 1'b1;
    base     = 32'd3;
    log_key  = 32'hFF;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) chk("abort_no_valid", out_valid, 1'b0);
    end
    chk("abort_out_valid", out_valid, 1'b0);
    run_op(32'd5, 32'd3, 1, 0);
    chk("k125", key, 32'd125);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] bs, ex;
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0: begin bs = $urandom_range(0, 20); ex = $urandom_range(0, 40); end
        1: begin bs = $urandom; ex = $urandom_range(0, 4); end
        2: begin bs = $urandom_range(0, 3); ex = $urandom; end
        default: begin bs = $urandom; ex = $urandom; end
      endcase
      in_valid = 1'b0;
      for (int j = $urandom_range(0, 3); j > 0; j--) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      out_ready = 1'b0;
      run_op(bs, ex, $urandom_range(0, 3), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
